// File: rtl/intfxp_pkg.sv
// intfxp_pkg: shared types and constants for the integrate-and-dump accumulator.
package intfxp_pkg;

  // Integrator control states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Sample counter / window length width
  localparam int CNT_W = 16;

  // Default datapath geometry
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_CYCLES    = 1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

endpackage : intfxp_pkg

// File: rtl/fxp_delay.sv
// fxp_delay: DEPTH-stage data+valid delay line. Data in each stage only
// advances alongside a valid token, so the final stage holds its last value
// between strobes.
module fxp_delay #(
  parameter int W     = 24,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);

  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Shift valid every cycle; move data only behind a valid token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= v_i;
      if (v_i) begin
        data_q[0] <= d_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign d_o = data_q[DEPTH-1];
  assign v_o = valid_q[DEPTH-1];

endmodule : fxp_delay

// File: rtl/intfxp.sv
// intfxp: signed fixed-point integrate-and-dump accumulator. Sums `a` over
// windows of N accepted samples and emits each sum through a `cycles`-deep
// output pipeline. Optional saturation build: define INTFXP_SAT_EN.
module intfxp
  import intfxp_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int acc_width = DEF_ACC_WIDTH,
  parameter int cycles    = DEF_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [width-1:0]     a,
  input  logic                        in_valid,
  input  logic        [CNT_W-1:0]     dump_len,
  input  logic                        start,
  input  logic                        stop,
  output logic signed [acc_width-1:0] q,
  output logic                        q_valid,
  output logic                        busy,
  output logic                        ovf
);

  state_e                      state_q;
  logic signed [acc_width-1:0] acc_q;
  logic        [CNT_W-1:0]     count_q;
  logic        [CNT_W-1:0]     n_q;
  logic                        busy_q;

  logic signed [acc_width-1:0] sum_d;
  logic                        window_end;
  logic                        accept;
  logic                        push_v;

  // A sample counts only in RUN and only when not being stopped
  assign accept     = (state_q == RUN) && in_valid && !stop;
  assign window_end = (count_q == (n_q - CNT_ONE));
  assign push_v     = accept && window_end;

`ifdef INTFXP_SAT_EN
  localparam logic signed [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

  logic signed [acc_width:0] sum_wide;
  logic                      sat_hit;
  logic                      ovf_q;

  // One guard bit exposes overflow; clamp toward the sign of the true sum
  always_comb begin
    sum_wide = (acc_width+1)'(acc_q) + (acc_width+1)'(a);
    sat_hit  = sum_wide[acc_width] ^ sum_wide[acc_width-1];
    sum_d    = sum_wide[acc_width-1:0];
    if (sat_hit) begin
      sum_d = sum_wide[acc_width] ? ACC_MIN : ACC_MAX;
    end
  end

  assign ovf = ovf_q;
`else
  // Plain two's-complement add, wraps modulo 2^acc_width
  always_comb begin
    sum_d = acc_q + acc_width'(a);
  end

  assign ovf = 1'b0;
`endif

  // Control FSM with accumulator, counter and registered busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      n_q     <= CNT_ONE;
      busy_q  <= 1'b0;
`ifdef INTFXP_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            n_q     <= (dump_len == '0) ? CNT_ONE : dump_len;
            acc_q   <= '0;
            count_q <= '0;
`ifdef INTFXP_SAT_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
          end else if (in_valid) begin
            if (window_end) begin
              acc_q   <= '0;
              count_q <= '0;
            end else begin
              acc_q   <= sum_d;
              count_q <= count_q + CNT_ONE;
            end
`ifdef INTFXP_SAT_EN
            if (sat_hit) begin
              ovf_q <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  fxp_delay #(
    .W    (acc_width),
    .DEPTH(cycles)
  ) u_out (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (sum_d),
    .v_i  (push_v),
    .d_o  (q),
    .v_o  (q_valid)
  );

endmodule : intfxp

// File: doc/intfxp.md
# intfxp

Pipelined signed fixed-point integrate-and-dump accumulator. It is the inverse of the fixed-point subtractor/differencer stage: it sums `a` over windows of N accepted samples and emits each window sum through a `cycles`-deep output pipeline. It sits in the receive datapath after the sample-difference stage and feeds symbol-level correlation/sync logic.

## Interface
- `width`, 16, input sample width (signed)
- `acc_width`, 24, accumulator/output width (signed); must be ≥ `width`
- `cycles`, 1, output pipeline depth (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a`  in  `width`  signed input sample
- `in_valid`  in  1  `a` valid this cycle
- `dump_len`  in  16  window length N, sampled on accepted `start`
- `start`  in  1  begin windowed integration (IDLE only)
- `stop`  in  1  abort/stop integration
- `q`  out  `acc_width`  signed window sum
- `q_valid`  out  1  one-cycle strobe, `q` valid
- `busy`  out  1  high in RUN
- `ovf`  out  1  sticky overflow flag

## Operation
- FSM states: IDLE, RUN.
- IDLE: `start`=1 and `stop`=0 → RUN; latch N = `dump_len` (0 treated as 1); acc=0; count=0; clear `ovf`.
- RUN: each `in_valid` cycle: acc += sign-extended `a`; count += 1.
- When the accepted sample is the N-th: push (acc + `a`) into output pipeline; acc=0; count=0; stay in RUN. Windows are back-to-back with no gap cycle.
- `stop`=1 in RUN → IDLE. Partial window discarded; any sample that cycle is discarded. Sums already in the pipeline still emerge.
- `start` in RUN ignored. `stop` in IDLE ignored. `start`+`stop` in IDLE → stay IDLE.
- `in_valid` in IDLE ignored.
- Width rule: `a` sign-extended to `acc_width`; two's-complement add. Overflow handling per Configuration.

## Timing
- Reset (async assert, sync release): state IDLE, acc 0, count 0, all pipeline stages 0, `q`=0, `q_valid`=0, `busy`=0, `ovf`=0.
- Reset mid-window: everything cleared immediately, including in-flight pipeline sums. No `q_valid` after reset.
- Latency: the final sample is accepted at edge k. `q`/`q_valid` update at edge k+`cycles`−1 after that edge. With `cycles`=1 they are registered at edge k itself.
- `q_valid` is high exactly one cycle per completed window. `q` holds its last value between strobes.
- `busy` rises the cycle after the accepted `start` and falls the cycle after `stop`.
- N=1: every accepted sample produces a strobe. Continuous `in_valid` gives a strobe every cycle.
- count wraps are impossible: count resets at N ≤ 65535.

## Configuration
- `INTFXP_SAT_EN` defined:
  - acc add saturates to [−2^(acc_width−1), 2^(acc_width−1)−1].
  - Any saturation event sets `ovf` until the next accepted `start` or reset.
  - A saturated sum is still emitted.
- Undefined:
  - add wraps modulo 2^`acc_width`.
  - `ovf` tied 0.

## Structure
- Package `intfxp_pkg`:
  - FSM state enum (IDLE, RUN)
  - count width constant (16)
  - default width constants
- Sub-module `fxp_delay`: `cycles`-stage data+valid delay line with async active-low reset, used for the output pipeline.

## Test plan
- Reset, then `start` with `dump_len`=4, `cycles`=1; feed a=1,2,3,4 continuously → single `q_valid` with q=10 one edge after last sample; `busy`=1.
- `dump_len`=3, `cycles`=3; feed a=−5,2,1 then 7,7,7 continuously → q=−2 then q=21, strobes exactly 3 cycles apart, each 2 extra edges after the final sample.
- `dump_len`=0 → behaves as N=1: a=9,−9 → q=9 then q=−9 on consecutive cycles.
- `stop` with `in_valid` after 2 of 4 samples → no strobe; `busy` falls next cycle; a new `start` gives a fresh sum from 0.
- `width`=16, `acc_width`=16, N=2, a=32767,32767:
  - with `INTFXP_SAT_EN` → q=32767, `ovf`=1
  - without → q=−2, `ovf`=0
- Assert `rst_n` low while a sum is in a 3-deep pipeline → `q`=0, `q_valid` never pulses, state IDLE.
